// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg
//   Shared types and constants for the EX-stage ALU control block.
//   - alu_op_e   : 4-bit Operation codes driven to the ALU
//   - aluop_e    : 2-bit ALUOp class from the main decoder
//   - md_op_e    : Funct3 encodings of the RV32M ops
//   - md_state_e : multiply/divide sequencer states
//   - F7_*       : the Funct7 values an R-type instruction may legally carry
//   Helper functions classify an M op by operand signedness and kind.
package alu_ctrl_pkg;

   typedef enum logic [3:0] {
      OP_AND     = 4'b0000,
      OP_OR      = 4'b0001,
      OP_ADD     = 4'b0010,
      OP_SUB     = 4'b0011,
      OP_XOR     = 4'b0100,
      OP_SLL     = 4'b0101,
      OP_SRL     = 4'b0110,
      OP_SLT     = 4'b0111,
      OP_BEQ     = 4'b1000,
      OP_SRA     = 4'b1001,
      OP_SLTU    = 4'b1010,
      OP_ILLEGAL = 4'b1111
   } alu_op_e;

   typedef enum logic [1:0] {
      ALUOP_MEM    = 2'b00,   // LW/SW/AUIPC
      ALUOP_BRANCH = 2'b01,
      ALUOP_RI     = 2'b10,   // R-type and I-type arithmetic
      ALUOP_JAL    = 2'b11    // JAL/LUI
   } aluop_e;

   typedef enum logic [2:0] {
      MD_MUL    = 3'b000,
      MD_MULH   = 3'b001,
      MD_MULHSU = 3'b010,
      MD_MULHU  = 3'b011,
      MD_DIV    = 3'b100,
      MD_DIVU   = 3'b101,
      MD_REM    = 3'b110,
      MD_REMU   = 3'b111
   } md_op_e;

   typedef enum logic [1:0] {
      MD_IDLE = 2'b00,
      MD_RUN  = 2'b01,
      MD_DONE = 2'b10
   } md_state_e;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   // rs1 is treated as signed by MULH, MULHSU, DIV and REM
   function automatic logic md_signed_a(input logic [2:0] op);
      return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
   endfunction

   // rs2 is treated as signed by MULH, DIV and REM
   function automatic logic md_signed_b(input logic [2:0] op);
      return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
   endfunction

   // Funct3[2] separates the divide family from the multiply family
   function automatic logic md_is_div(input logic [2:0] op);
      return op[2];
   endfunction

endpackage

// File: rtl/md_iter_core.sv
// md_iter_core
//   Iterative multiply/divide datapath working on operand magnitudes.
//   Multiply: shift-add into a 2*XLEN accumulator, STEP multiplier bits per cycle.
//   Divide:   restoring shift-subtract, STEP quotient bits per cycle.
//             The accumulator holds {remainder, dividend/quotient}.
//   Ports:
//     clk, reset : clock, synchronous active-high reset
//     load       : capture a, b, op and the result signs; prime the accumulator
//     busy       : perform one iteration this cycle
//     last       : final iteration; register the sign-corrected result
//     op         : Funct3 of the M op
//     a, b       : rs1 / rs2 operands
//     result     : registered result, held until the next final iteration
module md_iter_core
   import alu_ctrl_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int STEP = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            load,
   input  logic            busy,
   input  logic            last,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic [XLEN-1:0] result
);

   localparam int SW = XLEN + STEP;

   logic [2*XLEN-1:0] acc, acc_nxt;
   logic [XLEN-1:0]   opnd;          // multiplicand or divisor magnitude
   logic [2:0]        op_q;
   logic              neg_main_q;    // negate product / quotient
   logic              neg_rem_q;     // negate remainder (sign of dividend)

   logic              a_neg, b_neg;
   logic [XLEN-1:0]   mag_a, mag_b;

   logic [SW-1:0]     sum, hi_ext, mc_ext, dig_ext;
   logic [XLEN:0]     trial;
   logic [XLEN-1:0]   rem_w, quo_w;
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   res_nxt;

   // Operand magnitudes at load time
   always_comb begin
      a_neg = md_signed_a(op) & a[XLEN-1];
      b_neg = md_signed_b(op) & b[XLEN-1];
      mag_a = a_neg ? -a : a;
      mag_b = b_neg ? -b : b;
   end

   // One iteration of STEP bits
   always_comb begin
      acc_nxt = acc;
      sum     = '0;
      hi_ext  = {{STEP{1'b0}}, acc[2*XLEN-1:XLEN]};
      mc_ext  = {{STEP{1'b0}}, opnd};
      dig_ext = {{XLEN{1'b0}}, acc[STEP-1:0]};
      trial   = '0;
      rem_w   = acc[2*XLEN-1:XLEN];
      quo_w   = acc[XLEN-1:0];
      if (md_is_div(op_q)) begin
         for (int i = 0; i < STEP; i++) begin
            trial = {rem_w, quo_w[XLEN-1]};
            quo_w = {quo_w[XLEN-2:0], 1'b0};
            if (trial >= {1'b0, opnd}) begin
               trial    = trial - {1'b0, opnd};
               quo_w[0] = 1'b1;
            end
            // remainder stays below the divisor, so the top bit is always zero
            rem_w = trial[XLEN-1:0];
         end
         acc_nxt = {rem_w, quo_w};
      end else begin
         // low multiplier digit times multiplicand added into the high half,
         // then the whole accumulator shifts right by STEP
         sum     = hi_ext + mc_ext * dig_ext;
         acc_nxt = {sum, acc[XLEN-1:STEP]};
      end
   end

   // Sign correction of the value the final iteration produces
   always_comb begin
      prod_fix = neg_main_q ? -acc_nxt : acc_nxt;
      res_nxt  = '0;
      case (op_q)
         MD_MUL:                       res_nxt = prod_fix[XLEN-1:0];
         MD_MULH, MD_MULHSU, MD_MULHU: res_nxt = prod_fix[2*XLEN-1:XLEN];
         MD_DIV, MD_DIVU:              res_nxt = neg_main_q ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
         default:                      res_nxt = neg_rem_q ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc        <= '0;
         opnd       <= '0;
         op_q       <= MD_MUL;
         neg_main_q <= 1'b0;
         neg_rem_q  <= 1'b0;
         result     <= '0;
      end else if (load) begin
         op_q      <= op;
         neg_rem_q <= a_neg;
         if (md_is_div(op)) begin
            acc        <= {{XLEN{1'b0}}, mag_a};
            opnd       <= mag_b;
            // divide by zero keeps the all-ones quotient whatever the dividend sign
            neg_main_q <= (a_neg ^ b_neg) & (b != '0);
         end else begin
            acc        <= {{XLEN{1'b0}}, mag_b};
            opnd       <= mag_a;
            neg_main_q <= a_neg ^ b_neg;
         end
      end else if (busy) begin
         acc <= acc_nxt;
         if (last) result <= res_nxt;
      end
   end

endmodule

// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl
//   EX-stage ALU control: Operation decode plus an iterative RV32M sequencer.
//   Ports:
//     clk, reset           : clock, synchronous active-high reset
//     flush                : EX redirect; aborts a running M op
//     valid_in             : a valid instruction occupies EX
//     ALUOp, IsRType,
//     Funct7, Funct3       : decode inputs
//     SrcA, SrcB           : rs1 / rs2 operands
//     Operation            : 4-bit ALU code (combinational)
//     stall                : hold IF/ID/EX while an M op runs (combinational)
//     md_sel               : EX result mux takes md_result (one cycle, DONE)
//     md_result            : M op result, held until replaced
//     dbg_state            : sequencer state, for observation
//   Handshake: an M op is accepted in the cycle valid_in is high in IDLE
//   without flush; stall stays high until the cycle before DONE, and the
//   instruction retires in DONE when md_sel pulses with stall low.
module alu_exec_ctrl
   import alu_ctrl_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int ENABLE_M = 1,
   parameter int STEP     = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic            valid_in,
   input  logic [1:0]      ALUOp,
   input  logic            IsRType,
   input  logic [6:0]      Funct7,
   input  logic [2:0]      Funct3,
   input  logic [XLEN-1:0] SrcA,
   input  logic [XLEN-1:0] SrcB,
   output logic [3:0]      Operation,
   output logic            stall,
   output logic            md_sel,
   output logic [XLEN-1:0] md_result,
   output logic [1:0]      dbg_state
);

   localparam int ITERS = XLEN / STEP;
   localparam int CNT_W = $clog2(ITERS + 1);

   md_state_e        state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   alu_op_e          op_d;
   logic             is_m, start;
   logic             core_load, core_busy, core_last;

   // ---------------- Operation decode ----------------
   always_comb begin
      is_m = (ENABLE_M != 0) && (ALUOp == ALUOP_RI) && IsRType && (Funct7 == F7_MULDIV);
      op_d = OP_ADD;
      case (ALUOp)
         ALUOP_MEM, ALUOP_JAL: op_d = OP_ADD;
         ALUOP_BRANCH:         op_d = OP_BEQ;
         default: begin
            if (IsRType && (Funct7 != F7_BASE) && (Funct7 != F7_ALT) && (Funct7 != F7_MULDIV)) begin
               op_d = OP_ILLEGAL;
            end else if (IsRType && (Funct7 == F7_MULDIV)) begin
               // M op: the ALU result is not used, so ADD is a harmless filler
               op_d = (ENABLE_M != 0) ? OP_ADD : OP_ILLEGAL;
            end else begin
               case (Funct3)
                  3'b000:  op_d = (IsRType && (Funct7 == F7_ALT)) ? OP_SUB : OP_ADD;
                  3'b001:  op_d = OP_SLL;
                  3'b010:  op_d = OP_SLT;
                  3'b011:  op_d = OP_SLTU;
                  3'b100:  op_d = OP_XOR;
                  3'b101:  op_d = Funct7[5] ? OP_SRA : OP_SRL;
                  3'b110:  op_d = OP_OR;
                  default: op_d = OP_AND;
               endcase
            end
         end
      endcase
      Operation = op_d;
   end

   // ---------------- Sequencer FSM ----------------
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      core_load = 1'b0;
      core_busy = 1'b0;
      core_last = 1'b0;
      md_sel    = 1'b0;
      start     = valid_in & is_m & (state == MD_IDLE) & ~flush & ~reset;

      case (state)
         MD_IDLE: begin
            if (start) begin
               core_load = 1'b1;
               cnt_nxt   = ITERS[CNT_W-1:0];
               state_nxt = MD_RUN;
            end
         end
         MD_RUN: begin
            core_busy = 1'b1;
            cnt_nxt   = cnt - 1'b1;
            if (cnt == 1) begin
               core_last = 1'b1;
               state_nxt = MD_DONE;
            end
         end
         MD_DONE: begin
            md_sel    = 1'b1;
            state_nxt = MD_IDLE;
         end
         default: state_nxt = MD_IDLE;
      endcase

      if (flush) begin
         state_nxt = MD_IDLE;
         cnt_nxt   = '0;
         core_busy = 1'b0;
         core_last = 1'b0;
         md_sel    = 1'b0;
      end
      if (reset) md_sel = 1'b0;

      stall     = (start | (state == MD_RUN)) & ~flush & ~reset;
      dbg_state = state;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= MD_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   md_iter_core #(
      .XLEN (XLEN),
      .STEP (STEP)
   ) u_core (
      .clk    (clk),
      .reset  (reset),
      .load   (core_load),
      .busy   (core_busy),
      .last   (core_last),
      .op     (Funct3),
      .a      (SrcA),
      .b      (SrcB),
      .result (md_result)
   );

endmodule
